// File: rtl/sram_app_pkg.sv
// Shared constants and the lane-merge helper for the QDRII+ application-side responder.
package sram_app_pkg;

    localparam int unsigned DATA_W      = 144;
    localparam int unsigned LANES       = 16;
    localparam int unsigned LANE_W      = 9;
    localparam int unsigned SRAM_ADDR_W = 19;

    // Lanes with bw_n low take the new data; the rest keep the old word.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                     input logic [DATA_W-1:0] new_word,
                                                     input logic [LANES-1:0]  bw_n);
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (!bw_n[i]) begin
                merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_app_rdpipe.sv
// Read-return delay line: valid and data shift together, only the valid bits are reset.
module sram_app_rdpipe
    import sram_app_pkg::*;
#(
    parameter int unsigned Depth = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [Depth-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < Depth; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[Depth-1];
    assign out_data  = data_q[Depth-1];

endmodule

// File: rtl/sram_app_resp.sv
// Block-RAM stand-in for the QDRII+ controller port 0: calibration delay, masked writes,
// write-first collision bypass and fixed-latency read return.
module sram_app_resp
    import sram_app_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned RD_LAT       = 4,
    parameter int unsigned CALIB_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_calib_complete,
    input  logic                   app_wr_cmd0,
    input  logic [SRAM_ADDR_W-1:0] app_wr_addr0,
    input  logic [DATA_W-1:0]      app_wr_data0,
    input  logic [LANES-1:0]       app_wr_bw_n0,
    input  logic                   app_rd_cmd0,
    input  logic [SRAM_ADDR_W-1:0] app_rd_addr0,
    output logic                   app_rd_valid0,
    output logic [DATA_W-1:0]      app_rd_data0,
    output logic                   err_early_cmd
);

    localparam int unsigned MemDepth = 1 << ADDR_W;
    localparam int unsigned CntW     = $clog2(CALIB_CYCLES + 1);

    if (RD_LAT < 2 || RD_LAT > 16) begin : gen_bad_rd_lat
        $error("RD_LAT must be in 2..16");
    end
    if (ADDR_W < 1 || ADDR_W >= SRAM_ADDR_W) begin : gen_bad_addr_w
        $error("ADDR_W must be in 1..SRAM_ADDR_W-1");
    end
    if (CALIB_CYCLES < 1) begin : gen_bad_calib
        $error("CALIB_CYCLES must be at least 1");
    end

    // Calibration counter and sticky early-command flag
    logic [CntW-1:0] cnt_q;
    logic            calib_q;
    logic            err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            calib_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cnt_q != CntW'(CALIB_CYCLES)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == CntW'(CALIB_CYCLES)) begin
                calib_q <= 1'b1;
            end
            if ((app_wr_cmd0 || app_rd_cmd0) && !calib_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign init_calib_complete = calib_q;
    assign err_early_cmd       = err_q;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              unused_addr_hi;

    assign wr_en = app_wr_cmd0 && calib_q;
    assign rd_en = app_rd_cmd0 && calib_q;
    assign waddr = app_wr_addr0[ADDR_W-1:0];
    assign raddr = app_rd_addr0[ADDR_W-1:0];
    // Upper address bits alias by design.
    assign unused_addr_hi = ^{app_wr_addr0[SRAM_ADDR_W-1:ADDR_W],
                              app_rd_addr0[SRAM_ADDR_W-1:ADDR_W]};

    logic [DATA_W-1:0] mem [MemDepth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= lane_merge(mem[waddr], app_wr_data0, app_wr_bw_n0);
        end
    end

    // Write-first: a same-address write in the read cycle is merged into the returned word.
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_word   = mem[raddr];
        rd_data_d = rd_word;
        if (wr_en && (waddr == raddr)) begin
            rd_data_d = lane_merge(rd_word, app_wr_data0, app_wr_bw_n0);
        end
    end

    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= rd_data_d;
        end
    end

    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    sram_app_rdpipe #(
        .Depth(RD_LAT - 1)
    ) u_rdpipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_valid_q),
        .in_data  (rd_data_q),
        .out_valid(pipe_valid),
        .out_data (pipe_data)
    );

    assign app_rd_valid0 = pipe_valid;
    assign app_rd_data0  = pipe_valid ? pipe_data : '0;

endmodule

// File: tb/tb_sram_app_resp.sv
// Directed bench for sram_app_resp: calibration, masking, collision, streaming, reset.
module tb_sram_app_resp;
    import sram_app_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned RD_LAT = 4;
    localparam int unsigned CALIB  = 64;

    logic                   clk;
    logic                   rst_n;
    logic                   init_calib_complete;
    logic                   app_wr_cmd0;
    logic [SRAM_ADDR_W-1:0] app_wr_addr0;
    logic [DATA_W-1:0]      app_wr_data0;
    logic [LANES-1:0]       app_wr_bw_n0;
    logic                   app_rd_cmd0;
    logic [SRAM_ADDR_W-1:0] app_rd_addr0;
    logic                   app_rd_valid0;
    logic [DATA_W-1:0]      app_rd_data0;
    logic                   err_early_cmd;

    sram_app_resp #(
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .CALIB_CYCLES(CALIB)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_calib_complete(init_calib_complete),
        .app_wr_cmd0        (app_wr_cmd0),
        .app_wr_addr0       (app_wr_addr0),
        .app_wr_data0       (app_wr_data0),
        .app_wr_bw_n0       (app_wr_bw_n0),
        .app_rd_cmd0        (app_rd_cmd0),
        .app_rd_addr0       (app_rd_addr0),
        .app_rd_valid0      (app_rd_valid0),
        .app_rd_data0       (app_rd_data0),
        .err_early_cmd      (err_early_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DATA_W-1:0] Ones = {DATA_W{1'b1}};

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] stream_word(input int a);
        return {16{9'(a * 3 + 1)}};
    endfunction

    task automatic write(input logic [SRAM_ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input logic [LANES-1:0] bw_n);
        app_wr_cmd0  = 1'b1;
        app_wr_addr0 = addr;
        app_wr_data0 = data;
        app_wr_bw_n0 = bw_n;
        step();
        app_wr_cmd0  = 1'b0;
    endtask

    // Called right after the command edge: expects one pulse RD_LAT-1 edges later, zeros elsewhere.
    task automatic expect_pulse(input logic [DATA_W-1:0] exp, input string tag);
        for (int k = 0; k < int'(RD_LAT) + 2; k++) begin
            if (k > 0) step();
            check({tag, " valid"}, app_rd_valid0, (k == int'(RD_LAT) - 1));
            check({tag, " data"}, app_rd_data0, (k == int'(RD_LAT) - 1) ? exp : '0);
        end
    endtask

    task automatic read_check(input logic [SRAM_ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp,
                              input string tag);
        app_rd_cmd0  = 1'b1;
        app_rd_addr0 = addr;
        step();
        app_rd_cmd0  = 1'b0;
        expect_pulse(exp, tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        app_wr_cmd0  = 1'b0;
        app_wr_addr0 = '0;
        app_wr_data0 = '0;
        app_wr_bw_n0 = '1;
        app_rd_cmd0  = 1'b0;
        app_rd_addr0 = '0;
        repeat (3) @(negedge clk);
        check("rst calib", init_calib_complete, 1'b0);
        check("rst valid", app_rd_valid0, 1'b0);
        check("rst data", app_rd_data0, '0);
        check("rst err", err_early_cmd, 1'b0);

        // Calibration window with an early read at edge 10
        rst_n = 1'b1;
        for (int e = 0; e < 70; e++) begin
            app_rd_cmd0  = (e == 10);
            app_rd_addr0 = 19'd5;
            step();
            app_rd_cmd0 = 1'b0;
            check($sformatf("calib e%0d", e), init_calib_complete, (e >= int'(CALIB)));
            check($sformatf("err e%0d", e), err_early_cmd, (e >= 10));
            check($sformatf("early valid e%0d", e), app_rd_valid0, 1'b0);
        end

        write(19'd5, {8{18'h2A5A5}}, 16'h0000);
        read_check(19'd5, {8{18'h2A5A5}}, "basic");

        write(19'd7, Ones, 16'h0000);
        write(19'd7, '0, 16'hFFFE);
        read_check(19'd7, {{15{9'h1FF}}, 9'h000}, "mask_lane0");

        write(19'd8, Ones, 16'h0000);
        write(19'd8, '0, 16'h5555);
        read_check(19'd8, {8{9'h000, 9'h1FF}}, "mask_odd");

        // Same-cycle write and read of addr 9
        write(19'd9, Ones, 16'h0000);
        app_wr_cmd0  = 1'b1;
        app_wr_addr0 = 19'd9;
        app_wr_data0 = {135'd0, 9'h123};
        app_wr_bw_n0 = 16'hFFFE;
        app_rd_cmd0  = 1'b1;
        app_rd_addr0 = 19'd9;
        step();
        app_wr_cmd0 = 1'b0;
        app_rd_cmd0 = 1'b0;
        expect_pulse({{15{9'h1FF}}, 9'h123}, "collision");
        read_check(19'd9, {{15{9'h1FF}}, 9'h123}, "after_coll");

        // Write and read in the same cycle to different addresses: no bypass
        app_wr_cmd0  = 1'b1;
        app_wr_addr0 = 19'd9;
        app_wr_data0 = {135'd0, 9'h055};
        app_wr_bw_n0 = 16'hFFFE;
        app_rd_cmd0  = 1'b1;
        app_rd_addr0 = 19'd7;
        step();
        app_wr_cmd0 = 1'b0;
        app_rd_cmd0 = 1'b0;
        expect_pulse({{15{9'h1FF}}, 9'h000}, "no_bypass");
        read_check(19'd9, {{15{9'h1FF}}, 9'h055}, "diff_addr_wr");

        // Streaming: 32 back-to-back reads
        for (int a = 0; a < 32; a++) write(19'(a), stream_word(a), 16'h0000);
        for (int k = 0; k < 32 + int'(RD_LAT) + 1; k++) begin
            int  j;
            logic exp_v;
            app_rd_cmd0  = (k < 32);
            app_rd_addr0 = 19'(k);
            step();
            j     = k - (int'(RD_LAT) - 1);
            exp_v = (j >= 0) && (j < 32);
            check($sformatf("stream valid k%0d", k), app_rd_valid0, exp_v);
            check($sformatf("stream data k%0d", k), app_rd_data0, exp_v ? stream_word(j) : '0);
        end
        app_rd_cmd0 = 1'b0;

        write(19'h00405, {16{9'h0C3}}, 16'h0000);
        read_check(19'h00005, {16{9'h0C3}}, "alias_lo");
        read_check(19'h7FC05, {16{9'h0C3}}, "alias_hi");

        // Reset with reads in flight
        for (int i = 1; i <= 3; i++) begin
            app_rd_cmd0  = 1'b1;
            app_rd_addr0 = 19'(i);
            step();
        end
        app_rd_cmd0 = 1'b0;
        step();
        check("flight valid", app_rd_valid0, 1'b1);
        check("flight data", app_rd_data0, stream_word(1));
        rst_n = 1'b0;
        #1;
        check("async valid", app_rd_valid0, 1'b0);
        check("async data", app_rd_data0, '0);
        check("async calib", init_calib_complete, 1'b0);
        check("async err", err_early_cmd, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < int'(CALIB) + 4; c++) begin
            step();
            check($sformatf("post_rst valid c%0d", c), app_rd_valid0, 1'b0);
        end
        check("recal", init_calib_complete, 1'b1);
        read_check(19'd2, stream_word(2), "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_app_resp.md
# sram_app_resp

Synthesizable responder for the QDRII+ SRAM controller application interface (port 0): accepts write and read commands and returns read data after a fixed latency. It is backed by on-chip block RAM. It is the memory-side counterpart of the SRAM-backed FIFO, and it stands in for the MIG core in simulation and on boards without QDRII+ parts. It also models calibration delay and byte-write masking.

## Interface
- ADDR_W, 10: number of low address bits decoded; depth = 2^ADDR_W words of 144 bits.
- RD_LAT, 4: read command to `app_rd_valid0` latency in cycles, legal range 2..16.
- CALIB_CYCLES, 64: cycles after reset release before `init_calib_complete` rises, minimum 1.
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- init_calib_complete  out  1  high once calibration delay has elapsed.
- app_wr_cmd0  in  1  write strobe, one word per cycle.
- app_wr_addr0  in  19  write address; only bits [ADDR_W-1:0] are used.
- app_wr_data0  in  144  write data, 16 lanes of 9 bits.
- app_wr_bw_n0  in  16  active-low lane enables; bit i covers data[9i+8:9i].
- app_rd_cmd0  in  1  read strobe.
- app_rd_addr0  in  19  read address; only bits [ADDR_W-1:0] are used.
- app_rd_valid0  out  1  read data valid, single-cycle pulse per read.
- app_rd_data0  out  144  read data; 0 when `app_rd_valid0` is low.
- err_early_cmd  out  1  sticky flag: a command arrived before `init_calib_complete`.

## Operation
- **Calibration:** a counter counts from 0 to CALIB_CYCLES after `rst_n` is released. `init_calib_complete` goes to 1 when the count reaches CALIB_CYCLES and stays at 1 until the next reset.
- **Early commands:** a write or read strobe while `init_calib_complete` = 0 is ignored: no memory update and no valid pulse. It sets `err_early_cmd`.
- **Write:** on a cycle with `app_wr_cmd0` = 1, every lane i with bw_n[i] = 0 of mem[addr] takes the corresponding data lane at that clock edge. Lanes with bw_n[i] = 1 keep their old value.
- **Read:** on a cycle with `app_rd_cmd0` = 1, mem[addr] is sampled. `app_rd_valid0` pulses for exactly one cycle, RD_LAT cycles later, with that data.
- **Throughput:** one read and one write may issue every cycle with no backpressure. The read pipeline holds up to RD_LAT reads in flight.
- **Same-cycle collision:** a read and write in the same cycle to the same decoded address is write-first. The returned word is old data merged with the enabled new lanes.
- **Later reads** always return the most recent write.
- **Address aliasing:** bits [18:ADDR_W] are ignored, so addresses that differ only there alias the same word.
- **Memory contents** are not reset and read as X in simulation until written.

## Timing
- **Reset values:** `init_calib_complete` = 0, `app_rd_valid0` = 0, `app_rd_data0` = 0, `err_early_cmd` = 0. The calibration counter and all read-pipeline valid bits are cleared.
- **Reset assertion is asynchronous.** All in-flight reads are discarded and `app_rd_valid0` drops immediately.
- **Calibration timing:** with `rst_n` released before edge 0, `init_calib_complete` is first high after edge CALIB_CYCLES.
- **Read latency:** command accepted at edge t gives `app_rd_valid0` high in the cycle following edge t+RD_LAT-1. Measured in cycles from the command cycle, the latency is exactly RD_LAT.
- **Read pipeline structure:** one BRAM read register, then RD_LAT-1 delay stages. Valid and data travel together.
- **Data output gating:** `app_rd_data0` is driven 0 when not valid. No stale data appears on the bus.
- **Back-to-back reads** produce back-to-back valid pulses in command order.
- **Write visibility:** a write at edge t is visible to a read issued at edge t (via bypass) and to any later read.

## Structure
- Package `sram_app_pkg` holds:
  - constants DATA_W = 144, LANES = 16, LANE_W = 9, SRAM_ADDR_W = 19;
  - a lane-merge function (old, new, bw_n) → merged word, used by both the write path and the bypass.
- Sub-module `sram_app_rdpipe`: parameterized delay line (valid + DATA_W data, depth RD_LAT-1) with asynchronous clear of the valid bits only.
- The top level contains:
  - the calibration counter;
  - the BRAM array with one write and one read port;
  - the collision bypass;
  - the error flag.

## Test plan
- **Calibration:** reset, CALIB_CYCLES = 64. Expect `init_calib_complete` low through edge 63 and high from edge 64 on. A read at cycle 10 gives no valid pulse and sets `err_early_cmd`.
- **Basic write/read:** write 0x…A5 to addr 5 with bw_n = 0, then read addr 5 with RD_LAT = 4. Expect one valid pulse 4 cycles after the read, data equal to the written word, and data = 0 on all other cycles.
- **Byte masking:** write all-ones to addr 7, then write all-zeros with bw_n = 0xFFFE. The read returns lane 0 = 0 and lanes 1..15 = 0x1FF.
- **Collision:** same-cycle write 0x123 (lane 0 only) and read of addr 9, which previously held all-ones. Expect the returned word with lane 0 = 0x123 and the remaining lanes all-ones.
- **Streaming and aliasing:** 32 back-to-back reads of addrs 0..31 give 32 contiguous valid pulses in order. A write to addr 0x00405 with ADDR_W = 10 reads back at addr 5.
- **Reset mid-flight:** three reads issued, `rst_n` pulled low one cycle later. Expect valid to drop immediately and no pulses after release until new commands are issued following recalibration.
